// File: rtl/interp_lut_stream.sv
// rtl/interp_lut_stream.sv - streaming table lookup with linear interpolation between adjacent entries
module interp_lut_stream #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 10,
  parameter int FWIDTH = 8,
  parameter int WRAP   = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [AWIDTH-1:0]          wr_addr,
  input  logic signed [DWIDTH-1:0]   wr_data,
  input  logic [AWIDTH+FWIDTH-1:0]   i_tdata,
  input  logic                       i_tlast,
  input  logic                       i_tvalid,
  output logic                       i_tready,
  output logic signed [DWIDTH-1:0]   o_tdata,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       o_tready
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int PW    = DWIDTH + FWIDTH + 2;
  localparam logic signed [PW-1:0] RND = PW'(2 ** (FWIDTH - 1));

  logic signed [DWIDTH-1:0] mem_q [DEPTH];

  logic                     ce;
  logic [AWIDTH-1:0]        rd_addr;
  logic [AWIDTH-1:0]        nxt_addr;
  logic [FWIDTH-1:0]        rd_frac;

  logic                     s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
  logic signed [DWIDTH-1:0] s1_y0_d, s1_y0_q, s1_y1_d, s1_y1_q;
  logic [FWIDTH-1:0]        s1_frac_d, s1_frac_q;

  logic                     s2_valid_d, s2_valid_q, s2_last_d, s2_last_q;
  logic signed [DWIDTH-1:0] s2_y0_d, s2_y0_q;
  logic signed [DWIDTH:0]   s2_diff_d, s2_diff_q;
  logic [FWIDTH-1:0]        s2_frac_d, s2_frac_q;

  logic                     s3_valid_d, s3_valid_q, s3_last_d, s3_last_q;
  logic signed [DWIDTH-1:0] s3_y0_d, s3_y0_q;
  logic signed [PW-1:0]     s3_prod_d, s3_prod_q;

  logic                     o_tvalid_d, o_tvalid_q, o_tlast_d, o_tlast_q;
  logic signed [DWIDTH-1:0] o_tdata_d, o_tdata_q;

  // Table writes are independent of the stream; reads see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_addr  = i_tdata[AWIDTH+FWIDTH-1:FWIDTH];
  assign rd_frac  = i_tdata[FWIDTH-1:0];
  assign ce       = ~o_tvalid_q | o_tready;
  assign i_tready = ce & reset_n;

  always_comb begin
    nxt_addr = rd_addr + AWIDTH'(1);
    if (rd_addr == {AWIDTH{1'b1}}) begin
      nxt_addr = (WRAP != 0) ? '0 : rd_addr;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_y0_d    = s1_y0_q;
    s1_y1_d    = s1_y1_q;
    s1_frac_d  = s1_frac_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_y0_d    = s2_y0_q;
    s2_diff_d  = s2_diff_q;
    s2_frac_d  = s2_frac_q;
    s3_valid_d = s3_valid_q;
    s3_last_d  = s3_last_q;
    s3_y0_d    = s3_y0_q;
    s3_prod_d  = s3_prod_q;
    o_tvalid_d = o_tvalid_q;
    o_tlast_d  = o_tlast_q;
    o_tdata_d  = o_tdata_q;
    // Everything moves together; a stalled S1 keeps its captured entries.
    if (ce) begin
      s1_valid_d = i_tvalid;
      s1_last_d  = i_tlast;
      s1_y0_d    = mem_q[rd_addr];
      s1_y1_d    = mem_q[nxt_addr];
      s1_frac_d  = rd_frac;

      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_y0_d    = s1_y0_q;
      s2_diff_d  = $signed({s1_y1_q[DWIDTH-1], s1_y1_q}) - $signed({s1_y0_q[DWIDTH-1], s1_y0_q});
      s2_frac_d  = s1_frac_q;

      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
      s3_y0_d    = s2_y0_q;
      s3_prod_d  = PW'(s2_diff_q) * PW'($signed({1'b0, s2_frac_q}));

      // Result stays between y0 and y1, so dropping the upper bits loses nothing.
      o_tvalid_d = s3_valid_q;
      o_tlast_d  = s3_last_q;
      o_tdata_d  = DWIDTH'(PW'(s3_y0_q) + ((s3_prod_q + RND) >>> FWIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_y0_q    <= '0;
      s1_y1_q    <= '0;
      s1_frac_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_y0_q    <= '0;
      s2_diff_q  <= '0;
      s2_frac_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_y0_q    <= '0;
      s3_prod_q  <= '0;
      o_tvalid_q <= 1'b0;
      o_tlast_q  <= 1'b0;
      o_tdata_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_y0_q    <= s1_y0_d;
      s1_y1_q    <= s1_y1_d;
      s1_frac_q  <= s1_frac_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_y0_q    <= s2_y0_d;
      s2_diff_q  <= s2_diff_d;
      s2_frac_q  <= s2_frac_d;
      s3_valid_q <= s3_valid_d;
      s3_last_q  <= s3_last_d;
      s3_y0_q    <= s3_y0_d;
      s3_prod_q  <= s3_prod_d;
      o_tvalid_q <= o_tvalid_d;
      o_tlast_q  <= o_tlast_d;
      o_tdata_q  <= o_tdata_d;
    end
  end

  assign o_tvalid = o_tvalid_q;
  assign o_tlast  = o_tlast_q;
  assign o_tdata  = o_tdata_q;

endmodule
